sfr_bank_param: RTL

Parametrised special-function-register bank with a simple write/read request interface. It replaces the fixed four-register block with the following additions:
- configurable data width and register count
- per-register access type (RW / RO / W1C) and reset values
- honoured byte strobes, plus address error reporting
- concurrent read and write, with a registered one-cycle response on each path
- hardware status set inputs and a masked interrupt output

It sits between the bus-side agent or bridge and the peripheral datapath.

---
 rtl/sfr_bank_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sfr_bank_param.sv
// Parametrised special-function-register bank.
// Independent write and read request paths, each answered by a registered
// one-cycle response. Registers are RW, RO (live hardware value) or W1C
// (hardware-set, software-clear). The interrupt output is the registered
// OR-reduction of status AND mask.
module sfr_bank_param #(
    parameter int                          DATA_W     = 32,
    parameter int                          ADDR_W     = 32,
    parameter int                          NUM_REGS   = 4,
    // Access code per register, index 0 in the LSBs: 0=RW, 1=RO, 2=W1C.
    // Register 1 holds interrupt status (W1C); register 2 holds the mask (RW).
    parameter logic [2*NUM_REGS-1:0]       ACCESS     = {2'd0, 2'd0, 2'd2, 2'd0},
    parameter logic [DATA_W*NUM_REGS-1:0]  RESET_VALS = {32'h0, 32'h1, 32'h0, 32'h5},
    parameter int                          STS_IDX    = 1,
    parameter int                          MSK_IDX    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_wr_en,
    input  logic [ADDR_W-1:0]            i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W/8-1:0]          i_wstrobe,
    output logic                         o_wready,
    output logic                         o_werr,
    input  logic                         i_rd_en,
    input  logic [ADDR_W-1:0]            i_raddr,
    output logic [DATA_W-1:0]            o_rdata,
    output logic                         o_rvalid,
    output logic                         o_rerr,
    input  logic [DATA_W*NUM_REGS-1:0]   i_hw_set,
    input  logic [DATA_W*NUM_REGS-1:0]   i_hw_status,
    output logic [DATA_W*NUM_REGS-1:0]   o_regs,
    output logic                         o_irq
);

    localparam int         BYTES   = DATA_W / 8;
    localparam int         OFF_W   = $clog2(BYTES);
    localparam logic [1:0] ACC_RW  = 2'd0;
    localparam logic [1:0] ACC_W1C = 2'd2;

    // Register index addressed by a byte address.
    function automatic logic [ADDR_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
        return addr >> OFF_W;
    endfunction

    // Word-aligned and inside the bank; anything beyond NUM_REGS is an error, never aliased.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr[OFF_W-1:0] == '0) && (index_of(addr) < ADDR_W'(NUM_REGS));
    endfunction

    // Expand byte strobes into a bit mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [BYTES-1:0] strobe);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < BYTES; k++) begin
            m[8*k +: 8] = {8{strobe[k]}};
        end
        return m;
    endfunction

    // RW and W1C registers hold flops; every other code reads live hardware status.
    function automatic logic is_stored(input int idx);
        return (ACCESS[2*idx +: 2] == ACC_RW) || (ACCESS[2*idx +: 2] == ACC_W1C);
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rdata_d;
    logic              wr_ok;
    logic              rd_ok;
    logic              wready_q;
    logic              werr_q;
    logic              rvalid_q;
    logic              rerr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              irq_q;

    // Slices of the hardware inputs that belong to other access types are intentionally ignored.
    logic unused_hw;
    assign unused_hw = ^{i_hw_set, i_hw_status};

    assign wr_ok = i_wr_en && addr_legal(i_waddr);
    assign rd_ok = i_rd_en && addr_legal(i_raddr);
    assign wmask = lane_mask(i_wstrobe);

    // Next register state: strobed RW merge, W1C clear with hardware set taking priority.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (ACCESS[2*i +: 2] == ACC_RW) begin
                if (wr_ok && (index_of(i_waddr) == ADDR_W'(i))) begin
                    regs_d[i] = (regs_q[i] & ~wmask) | (i_wdata & wmask);
                end
            end else if (ACCESS[2*i +: 2] == ACC_W1C) begin
                regs_d[i] = (regs_q[i]
                             & ~((wr_ok && (index_of(i_waddr) == ADDR_W'(i))) ? (i_wdata & wmask) : '0))
                            | i_hw_set[i*DATA_W +: DATA_W];
            end else begin
                regs_d[i] = '0;
            end
        end
    end

    // Read mux on the pre-write state; illegal addresses return zero.
    always_comb begin
        rdata_d = '0;
        if (rd_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (index_of(i_raddr) == ADDR_W'(i)) begin
                    rdata_d = is_stored(i) ? regs_q[i] : i_hw_status[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register storage, loaded with per-register reset values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= is_stored(i) ? RESET_VALS[i*DATA_W +: DATA_W] : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Write and read response pulses; read data holds between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wready_q <= 1'b0;
            werr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wready_q <= i_wr_en;
            werr_q   <= i_wr_en && !addr_legal(i_waddr);
            rvalid_q <= i_rd_en;
            rerr_q   <= i_rd_en && !addr_legal(i_raddr);
            if (i_rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Interrupt follows the stored status and mask one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(regs_q[STS_IDX] & regs_q[MSK_IDX]);
        end
    end

    // Flatten stored contents; RO slots have no storage and read as zero here.
    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_regs[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign o_wready = wready_q;
    assign o_werr   = werr_q;
    assign o_rvalid = rvalid_q;
    assign o_rerr   = rerr_q;
    assign o_rdata  = rdata_q;
    assign o_irq    = irq_q;

endmodule
